// File: rtl/input_debounce_pkg.sv
// rtl/input_debounce_pkg.sv - shared FSM state encoding and idle level for the switch debouncer
package input_debounce_pkg;

    typedef enum logic [1:0] {
        S_HIGH     = 2'd0,
        S_FALL_CHK = 2'd1,
        S_LOW      = 2'd2,
        S_RISE_CHK = 2'd3
    } state_t;

    // Released switch reads high; also the reset value of every level-holding flop.
    localparam logic SW_IDLE = 1'b1;

endpackage

// File: rtl/input_debounce_if.sv
// rtl/input_debounce_if.sv - switch input / PC-side outputs bundle for the debouncer
interface input_debounce_if;
    logic sw_raw;
    logic wait_req;
    logic flag;
    logic advance;
    logic busy;

    modport master (
        output sw_raw,
        output wait_req,
        input  flag,
        input  advance,
        input  busy
    );

    modport slave (
        input  sw_raw,
        input  wait_req,
        output flag,
        output advance,
        output busy
    );
endinterface

// File: rtl/input_debounce_sync2.sv
// rtl/input_debounce_sync2.sv - two-flop synchroniser with synchronous reset to RESET_VAL
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= RESET_VAL;
            r_s2 <= RESET_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;
endmodule

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - switch debouncer feeding picoMIPS PC flag/advance; INPUT_STICKY_EN holds advance until wait_req drops
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input_debounce_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;
    logic             r_advance;
    logic             r_busy;

    sync2 #(
        .RESET_VAL (SW_IDLE)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.sw_raw),
        .o_q   (w_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_HIGH;
            r_cnt     <= '0;
            r_flag    <= SW_IDLE;
            r_advance <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
`ifdef INPUT_STICKY_EN
            if (!bus.wait_req)
                r_advance <= 1'b0;
`else
            r_advance <= 1'b0;
`endif
            case (r_state)
                S_HIGH: begin
                    if (!w_s) begin
                        r_state <= S_FALL_CHK;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                S_FALL_CHK: begin
                    if (w_s) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        r_flag  <= 1'b0;
                        r_busy  <= 1'b0;
                        // Only a press seen while the PC is stalled counts as an advance.
                        if (bus.wait_req)
                            r_advance <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                S_LOW: begin
                    if (w_s) begin
                        r_state <= S_RISE_CHK;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                S_RISE_CHK: begin
                    if (!w_s) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        r_flag  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_HIGH;
                    r_cnt   <= '0;
                    r_flag  <= SW_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flag    = r_flag;
    assign bus.advance = r_advance;
    assign bus.busy    = r_busy;
endmodule
